// File: rtl/prmcu_uart_pkg.sv
// Shared types and constants for the prmcu UART receive and transmit paths.
package prmcu_uart_pkg;

  localparam int unsigned UART_MIN_DATA_BITS = 5;
  localparam int unsigned UART_MAX_DATA_BITS = 9;
  localparam int unsigned UART_MIN_DIVIDER   = 2;
  localparam int unsigned UART_DIV_W         = 8;
  localparam int unsigned UART_DATA_W        = 9;
  localparam int unsigned UART_NBITS_W       = 4;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } uart_rx_state_t;

  // Out-of-range data-bit counts saturate to the supported 5..9 window.
  function automatic logic [UART_NBITS_W-1:0] clamp_data_bits(input logic [UART_NBITS_W-1:0] n);
    if (n < UART_NBITS_W'(UART_MIN_DATA_BITS)) return UART_NBITS_W'(UART_MIN_DATA_BITS);
    if (n > UART_NBITS_W'(UART_MAX_DATA_BITS)) return UART_NBITS_W'(UART_MAX_DATA_BITS);
    return n;
  endfunction

  function automatic logic [UART_DIV_W-1:0] clamp_divider(input logic [UART_DIV_W-1:0] d);
    if (d < UART_DIV_W'(UART_MIN_DIVIDER)) return UART_DIV_W'(UART_MIN_DIVIDER);
    return d;
  endfunction

endpackage

// File: rtl/prmcu_uart_bit_timer.sv
// Loadable down-counter; expire_c strobes for one cycle, load_val cycles after a load.
module prmcu_uart_bit_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire_c
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  // Counter parks at zero after expiry so the strobe fires once per load.
  assign expire_c = (cnt_q == W'(1));

endmodule

// File: rtl/prmcu_uart_rx.sv
// UART receive engine: synchronizes rx_i, samples mid-bit and presents words on a valid/ready stream.
module prmcu_uart_rx
  import prmcu_uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    n_parity_bits_i,
  input  logic [1:0]              n_stop_bits_i,
  input  logic [UART_NBITS_W-1:0] n_data_bits_i,
  input  logic [UART_DIV_W-1:0]   internal_clk_divider_i,
  input  logic                    rx_i,
  output logic [UART_DATA_W-1:0]  out_dat_o,
  output logic                    out_vld_o,
  input  logic                    out_rdy_i,
  output logic                    parity_err_o,
  output logic                    frame_err_o,
  output logic                    overrun_err_o
);

  localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [SYNC_N-1:0]       sync_q;
  logic                    rxs;
  uart_rx_state_t          state_q, state_d;

  logic [UART_DIV_W-1:0]   div_q;
  logic [UART_NBITS_W-1:0] nbits_q;
  logic                    par_en_q;
  logic                    stop2_q;
  logic [UART_NBITS_W-1:0] bit_idx_q;
  logic                    stop_idx_q;
  logic [UART_DATA_W-1:0]  data_q;
  logic                    par_err_q;
  logic                    frm_err_q;

  logic [UART_DIV_W-1:0]   div_in_c;
  logic                    tmr_load_c;
  logic [UART_DIV_W-1:0]   tmr_val_c;
  logic                    tmr_expire_c;
  logic                    cfg_capture_c;
  logic                    data_clear_c;
  logic                    data_shift_c;
  logic                    par_sample_c;
  logic                    stop_sample_c;
  logic                    commit_c;
  logic                    commit_ok_c;

  // Input synchronizer; idles high so reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_N-2:0], rx_i};
  end
  assign rxs = sync_q[SYNC_N-1];

  assign div_in_c = clamp_divider(internal_clk_divider_i);

  prmcu_uart_bit_timer #(.W(UART_DIV_W)) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .expire_c (tmr_expire_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= RX_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    tmr_load_c    = 1'b0;
    tmr_val_c     = div_q;
    cfg_capture_c = 1'b0;
    data_clear_c  = 1'b0;
    data_shift_c  = 1'b0;
    par_sample_c  = 1'b0;
    stop_sample_c = 1'b0;
    commit_c      = 1'b0;
    if (!en) begin
      state_d = RX_IDLE;
    end else begin
      case (state_q)
        RX_IDLE: begin
          if (!rxs) begin
            tmr_load_c    = 1'b1;
            tmr_val_c     = div_in_c >> 1;
            cfg_capture_c = 1'b1;
            state_d       = RX_START;
          end
        end
        RX_START: begin
          if (tmr_expire_c) begin
            if (rxs) begin
              state_d = RX_IDLE;
            end else begin
              tmr_load_c   = 1'b1;
              data_clear_c = 1'b1;
              state_d      = RX_DATA;
            end
          end
        end
        RX_DATA: begin
          if (tmr_expire_c) begin
            data_shift_c = 1'b1;
            tmr_load_c   = 1'b1;
            if (bit_idx_q == nbits_q - UART_NBITS_W'(1)) begin
              state_d = par_en_q ? RX_PARITY : RX_STOP;
            end
          end
        end
        RX_PARITY: begin
          if (tmr_expire_c) begin
            par_sample_c = 1'b1;
            tmr_load_c   = 1'b1;
            state_d      = RX_STOP;
          end
        end
        RX_STOP: begin
          if (tmr_expire_c) begin
            stop_sample_c = 1'b1;
            // Commit mid-stop-bit so a start edge right after the frame is caught.
            if (stop_idx_q == stop2_q) begin
              commit_c = 1'b1;
              state_d  = RX_IDLE;
            end else begin
              tmr_load_c = 1'b1;
            end
          end
        end
        default: state_d = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= UART_DIV_W'(UART_MIN_DIVIDER);
      nbits_q    <= UART_NBITS_W'(UART_MIN_DATA_BITS);
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
    end else begin
      if (cfg_capture_c) begin
        div_q    <= div_in_c;
        nbits_q  <= clamp_data_bits(n_data_bits_i);
        par_en_q <= n_parity_bits_i;
        stop2_q  <= (n_stop_bits_i >= 2'd2);
      end
      if (data_clear_c) begin
        bit_idx_q  <= '0;
        stop_idx_q <= 1'b0;
        data_q     <= '0;
        par_err_q  <= 1'b0;
        frm_err_q  <= 1'b0;
      end
      if (data_shift_c) begin
        data_q    <= data_q | (UART_DATA_W'(rxs) << bit_idx_q);
        bit_idx_q <= bit_idx_q + UART_NBITS_W'(1);
      end
      if (par_sample_c) par_err_q <= rxs ^ (^data_q);
      if (stop_sample_c) begin
        frm_err_q  <= frm_err_q | ~rxs;
        stop_idx_q <= 1'b1;
      end
    end
  end

  // Output register accepts a commit only when empty or draining this cycle.
  assign commit_ok_c = ~out_vld_o | out_rdy_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_dat_o     <= '0;
      out_vld_o     <= 1'b0;
      parity_err_o  <= 1'b0;
      frame_err_o   <= 1'b0;
      overrun_err_o <= 1'b0;
    end else begin
      overrun_err_o <= commit_c & ~commit_ok_c;
      if (commit_c && commit_ok_c) begin
        out_dat_o    <= data_q;
        parity_err_o <= par_err_q;
        frame_err_o  <= frm_err_q | ~rxs;
        out_vld_o    <= 1'b1;
      end else if (out_vld_o && out_rdy_i) begin
        out_vld_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prmcu_uart_rx.sv
// Self-checking bench for prmcu_uart_rx: directed table, randomized frames and multi-cycle corner cases.
module tb_prmcu_uart_rx;
  import prmcu_uart_pkg::*;

  logic       clk;
  logic       rst;
  logic       en;
  logic       n_parity_bits_i;
  logic [1:0] n_stop_bits_i;
  logic [3:0] n_data_bits_i;
  logic [7:0] internal_clk_divider_i;
  logic       rx_i;
  logic [8:0] out_dat_o;
  logic       out_vld_o;
  logic       out_rdy_i;
  logic       parity_err_o;
  logic       frame_err_o;
  logic       overrun_err_o;

  int n_checks = 0;
  int n_fails  = 0;
  int n_overrun = 0;

  typedef struct {
    logic [8:0] dat;
    logic       perr;
    logic       ferr;
  } word_t;

  typedef struct {
    int         div;
    int         nb;
    bit         par_en;
    int         nstop;
    logic [8:0] data;
    bit         par_bit;
    logic [1:0] stops;
    logic [8:0] exp_dat;
    bit         exp_perr;
    bit         exp_ferr;
  } vec_t;

  word_t exp_q[$];

  prmcu_uart_rx #(.SYNC_STAGES(2)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .en                     (en),
    .n_parity_bits_i        (n_parity_bits_i),
    .n_stop_bits_i          (n_stop_bits_i),
    .n_data_bits_i          (n_data_bits_i),
    .internal_clk_divider_i (internal_clk_divider_i),
    .rx_i                   (rx_i),
    .out_dat_o              (out_dat_o),
    .out_vld_o              (out_vld_o),
    .out_rdy_i              (out_rdy_i),
    .parity_err_o           (parity_err_o),
    .frame_err_o            (frame_err_o),
    .overrun_err_o          (overrun_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference: what a correct receiver reports for a frame, from the frame's own bits.
  function automatic word_t model(input logic [8:0] data, input int nb, input bit par_en,
                                  input bit par_bit, input int nstop, input logic [1:0] stops);
    word_t w;
    int ones = 0;
    w.dat = '0;
    for (int i = 0; i < nb; i++) begin
      w.dat[i] = data[i];
      ones += int'(data[i]);
    end
    w.perr = par_en && (int'(par_bit) != (ones % 2));
    w.ferr = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
    return w;
  endfunction

  function automatic bit even_par(input logic [8:0] data, input int nb);
    int ones = 0;
    for (int i = 0; i < nb; i++) ones += int'(data[i]);
    return bit'(ones % 2);
  endfunction

  // Scoreboard: every transferred word must match the oldest expected word.
  always @(negedge clk) begin
    if (overrun_err_o === 1'b1) n_overrun++;
    if (!rst && out_vld_o && out_rdy_i) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL unexpected_word: got dat 0x%0h, no word expected", out_dat_o);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        check("word_dat", 32'(out_dat_o), 32'(e.dat));
        check("word_perr", 32'(parity_err_o), 32'(e.perr));
        check("word_ferr", 32'(frame_err_o), 32'(e.ferr));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int d);
    rx_i = b;
    tick(d);
  endtask

  task automatic send_frame(input int d, input int nb, input bit par_en, input bit par_bit,
                            input logic [8:0] data, input int nstop, input logic [1:0] stops);
    drive_bit(1'b0, d);
    for (int i = 0; i < nb; i++) drive_bit(data[i], d);
    if (par_en) drive_bit(par_bit, d);
    for (int s = 0; s < nstop; s++) drive_bit(stops[s], d);
    rx_i = 1'b1;
  endtask

  task automatic set_cfg(input int div, input int nb, input bit par, input int nstop);
    internal_clk_divider_i = 8'(div);
    n_data_bits_i          = 4'(nb);
    n_parity_bits_i        = par;
    n_stop_bits_i          = 2'(nstop);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    vecs[0] = '{87, 9, 1'b1, 2, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
    vecs[1] = '{87, 9, 1'b1, 2, 9'h0A5, 1'b1, 2'b11, 9'h0A5, 1'b1, 1'b0};
    vecs[2] = '{87, 8, 1'b0, 1, 9'h03C, 1'b0, 2'b10, 9'h03C, 1'b0, 1'b1};
    vecs[3] = '{87, 8, 1'b0, 1, 9'h055, 1'b0, 2'b11, 9'h055, 1'b0, 1'b0};

    rst = 1'b1; en = 1'b1; rx_i = 1'b1; out_rdy_i = 1'b1;
    set_cfg(87, 9, 1'b1, 2);
    tick(3);
    rst = 1'b0;
    @(negedge clk);
    check("rst_dat", 32'(out_dat_o), 32'd0);
    check("rst_vld", 32'(out_vld_o), 32'd0);
    check("rst_perr", 32'(parity_err_o), 32'd0);
    check("rst_ferr", 32'(frame_err_o), 32'd0);
    check("rst_ovr", 32'(overrun_err_o), 32'd0);
    tick(2);

    // Directed table.
    for (int v = 0; v < 4; v++) begin
      word_t w;
      w.dat = vecs[v].exp_dat; w.perr = vecs[v].exp_perr; w.ferr = vecs[v].exp_ferr;
      set_cfg(vecs[v].div, vecs[v].nb, vecs[v].par_en, vecs[v].nstop);
      exp_q.push_back(w);
      send_frame(vecs[v].div, vecs[v].nb, vecs[v].par_en, vecs[v].par_bit,
                 vecs[v].data, vecs[v].nstop, vecs[v].stops);
      drive_bit(1'b1, 2 * vecs[v].div);
      wait_drain("table_drain", 10);
    end

    // 20 back-to-back random clean frames.
    set_cfg(87, 9, 1'b1, 2);
    for (int f = 0; f < 20; f++) begin
      logic [8:0] d9;
      d9 = 9'($urandom);
      exp_q.push_back(model(d9, 9, 1'b1, even_par(d9, 9), 2, 2'b11));
      send_frame(87, 9, 1'b1, even_par(d9, 9), d9, 2, 2'b11);
    end
    drive_bit(1'b1, 87);
    wait_drain("b2b_drain", 10);

    // Random configurations (including out-of-range values) with error injection.
    for (int f = 0; f < 25; f++) begin
      int raw_div, raw_nb, raw_stop, d, nb, nstop;
      bit par, pb;
      logic [8:0] d9;
      logic [1:0] st;
      raw_div  = $urandom_range(0, 24);
      raw_nb   = $urandom_range(0, 15);
      raw_stop = $urandom_range(0, 3);
      par      = bit'($urandom_range(0, 1));
      d        = (raw_div < 2) ? 2 : raw_div;
      nb       = (raw_nb < 5) ? 5 : ((raw_nb > 9) ? 9 : raw_nb);
      nstop    = (raw_stop == 0) ? 1 : ((raw_stop == 3) ? 2 : raw_stop);
      d9       = 9'($urandom);
      pb       = even_par(d9, nb) ^ ($urandom_range(0, 3) == 0);
      st       = ($urandom_range(0, 3) != 0) ? 2'b11 : 2'($urandom_range(0, 3));
      set_cfg(raw_div, raw_nb, par, raw_stop);
      exp_q.push_back(model(d9, nb, par, pb, nstop, st));
      send_frame(d, nb, par, pb, d9, nstop, st);
      drive_bit(1'b1, 2 * d);
      wait_drain("rand_drain", 10);
    end

    // Start glitch shorter than half a bit.
    set_cfg(87, 8, 1'b0, 1);
    drive_bit(1'b0, 20);
    drive_bit(1'b1, 100);
    check("glitch_idle", 32'(dut.state_q), 32'(RX_IDLE));
    check("glitch_vld", 32'(out_vld_o), 32'd0);

    // Enable dropped mid-frame abandons the frame.
    drive_bit(1'b0, 87);
    drive_bit(1'b0, 2 * 87);
    en = 1'b0;
    rx_i = 1'b1;
    tick(3);
    check("en_idle", 32'(dut.state_q), 32'(RX_IDLE));
    en = 1'b1;
    drive_bit(1'b1, 3 * 87);
    check("en_vld", 32'(out_vld_o), 32'd0);

    // Overrun: second frame dropped while first is held.
    n_overrun = 0;
    out_rdy_i = 1'b0;
    exp_q.push_back(model(9'h011, 8, 1'b0, 1'b0, 1, 2'b11));
    send_frame(87, 8, 1'b0, 1'b0, 9'h011, 1, 2'b11);
    drive_bit(1'b1, 87);
    send_frame(87, 8, 1'b0, 1'b0, 9'h022, 1, 2'b11);
    drive_bit(1'b1, 87);
    check("ovr_dat_held", 32'(out_dat_o), 32'h011);
    check("ovr_vld_held", 32'(out_vld_o), 32'd1);
    check("ovr_pulses", 32'(n_overrun), 32'd1);
    out_rdy_i = 1'b1;
    tick(2);
    check("ovr_vld_drop", 32'(out_vld_o), 32'd0);
    wait_drain("ovr_drain", 4);

    // Reset during data bit 4 with a word held in the output register.
    set_cfg(87, 9, 1'b1, 2);
    out_rdy_i = 1'b0;
    send_frame(87, 9, 1'b1, even_par(9'h0AA, 9), 9'h0AA, 2, 2'b11);
    drive_bit(1'b1, 87);
    check("pre_rst_vld", 32'(out_vld_o), 32'd1);
    drive_bit(1'b0, 87);
    drive_bit(1'b1, 87);
    drive_bit(1'b0, 87);
    drive_bit(1'b1, 87);
    drive_bit(1'b0, 87);
    drive_bit(1'b1, 43);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mid_rst_vld", 32'(out_vld_o), 32'd0);
    check("mid_rst_dat", 32'(out_dat_o), 32'd0);
    check("mid_rst_state", 32'(dut.state_q), 32'(RX_IDLE));
    drive_bit(1'b1, 3 * 87);
    out_rdy_i = 1'b1;
    exp_q.push_back(model(9'h1FF, 9, 1'b1, even_par(9'h1FF, 9), 2, 2'b11));
    send_frame(87, 9, 1'b1, even_par(9'h1FF, 9), 9'h1FF, 2, 2'b11);
    drive_bit(1'b1, 87);
    wait_drain("post_rst_drain", 10);
    check("total_overruns", 32'(n_overrun), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
